fir_filter_sequencer: RTL and testbench

- Frame-level controller for FIR_Filter; owns all of its control inputs.
- Sequences one frame: primes the input-sample RAM, streams N input addresses with start held, captures every valid_out into the output RAM at consecutive addresses, drains the pipeline, then signals done.
- Supports an on-demand readback sweep of the output RAM.
- Sits between the beamformer top-level control and the FIR_Filter instance.

---
 rtl/fir_filter_sequencer_if.sv | 33 +++
 rtl/fir_filter_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_fir_filter_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_sequencer_if.sv
// Control bus between the frame sequencer and one FIR_Filter instance.
// The sequencer drives every FIR control input; the filter only returns valid_out.
interface fir_filter_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] input_address;
  logic              input_read;
  logic              start;
  logic              valid_out;
  logic              output_write_en;
  logic              output_read_en;
  logic [ADDR_W-1:0] output_address;

  modport master (
    output input_address,
    output input_read,
    output start,
    input  valid_out,
    output output_write_en,
    output output_read_en,
    output output_address
  );

  modport slave (
    input  input_address,
    input  input_read,
    input  start,
    output valid_out,
    input  output_write_en,
    input  output_read_en,
    input  output_address
  );
endinterface

// File: rtl/fir_filter_sequencer.sv
// Frame sequencer for FIR_Filter: primes the input RAM, streams N addresses,
// captures valid_out into the output RAM, drains, and offers an output-RAM readback sweep.
module fir_filter_sequencer #(
  parameter int ADDR_W        = 11,
  parameter int CNT_W         = 12,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   readback_req,
  fir_filter_sequencer_if.master filt,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CNT_W-1:0]       out_count
);
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [IDLE_W-1:0] IDLE_ZERO  = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0] IDLE_ONE   = {{(IDLE_W-1){1'b0}}, 1'b1};
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    STREAM   = 3'd2,
    DRAIN    = 3'd3,
    FINISH   = 3'd4,
    READBACK = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  n_r, n_s;
  logic [CNT_W-1:0]  wr_ptr_r, wr_ptr_s;
  logic [CNT_W-1:0]  rd_ptr_r, rd_ptr_s;
  logic [CNT_W-1:0]  out_count_r, out_count_s;
  logic [ADDR_W-1:0] in_addr_r, in_addr_s;
  logic [IDLE_W-1:0] idle_r, idle_s;
  logic              in_read_r, in_read_s;
  logic              start_r, start_s;
  logic              rd_en_r, rd_en_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              error_r, error_s;
  logic              capture_s, write_en_s;

  // Capture strobe is combinational so it lines up with the filter's data_out; wr_ptr saturates at N.
  always_comb begin
    capture_s  = (state_r == STREAM) || (state_r == DRAIN);
    write_en_s = capture_s && filt.valid_out && (wr_ptr_r < n_r);
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_s     = state_r;
    n_s         = n_r;
    wr_ptr_s    = wr_ptr_r + {{(CNT_W-1){1'b0}}, write_en_s};
    rd_ptr_s    = CNT_ZERO;
    in_addr_s   = ADDR_ZERO;
    idle_s      = IDLE_ZERO;
    in_read_s   = 1'b0;
    start_s     = 1'b0;
    rd_en_s     = 1'b0;
    done_s      = 1'b0;
    error_s     = error_r;
    out_count_s = out_count_r;
    case (state_r)
      IDLE: begin
        if (go) begin
          error_s  = 1'b0;
          wr_ptr_s = CNT_ZERO;
          if (num_samples != CNT_ZERO) begin
            n_s       = num_samples;
            state_s   = PRIME;
            in_read_s = 1'b1;
          end else begin
            state_s     = FINISH;
            done_s      = 1'b1;
            out_count_s = CNT_ZERO;
          end
        end else if (readback_req) begin
          if (out_count_r != CNT_ZERO) begin
            state_s = READBACK;
            rd_en_s = 1'b1;
          end else begin
            state_s = FINISH;
            done_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PRIME: begin
        state_s   = STREAM;
        start_s   = 1'b1;
        in_read_s = 1'b1;
      end
      STREAM: begin
        start_s = 1'b1;
        if (CNT_W'(in_addr_r) == n_r - CNT_ONE) begin
          state_s   = DRAIN;
          in_addr_s = in_addr_r;
        end else begin
          in_read_s = 1'b1;
          in_addr_s = in_addr_r + ADDR_ONE;
        end
      end
      DRAIN: begin
        in_addr_s = in_addr_r;
        idle_s    = filt.valid_out ? IDLE_ZERO : idle_r + IDLE_ONE;
        if (wr_ptr_s == n_r) begin
          state_s     = FINISH;
          done_s      = 1'b1;
          out_count_s = wr_ptr_s;
        end else if (idle_s == IDLE_LIMIT) begin
          state_s     = FINISH;
          done_s      = 1'b1;
          error_s     = 1'b1;
          out_count_s = wr_ptr_s;
        end else begin
          start_s = 1'b1;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      READBACK: begin
        if (rd_ptr_r == out_count_r - CNT_ONE) begin
          state_s = FINISH;
          done_s  = 1'b1;
        end else begin
          rd_ptr_s = rd_ptr_r + CNT_ONE;
          rd_en_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      n_r         <= CNT_ZERO;
      wr_ptr_r    <= CNT_ZERO;
      rd_ptr_r    <= CNT_ZERO;
      out_count_r <= CNT_ZERO;
      in_addr_r   <= ADDR_ZERO;
      idle_r      <= IDLE_ZERO;
      in_read_r   <= 1'b0;
      start_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      n_r         <= n_s;
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      out_count_r <= out_count_s;
      in_addr_r   <= in_addr_s;
      idle_r      <= idle_s;
      in_read_r   <= in_read_s;
      start_r     <= start_s;
      rd_en_r     <= rd_en_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
    end
  end

  assign filt.input_address   = in_addr_r;
  assign filt.input_read      = in_read_r;
  assign filt.start           = start_r;
  assign filt.output_write_en = write_en_s;
  assign filt.output_read_en  = rd_en_r;
  assign filt.output_address  = capture_s ? wr_ptr_r[ADDR_W-1:0] : rd_ptr_r[ADDR_W-1:0];
  assign busy                 = busy_r;
  assign done                 = done_r;
  assign error                = error_r;
  assign out_count            = out_count_r;
endmodule

// File: tb/tb_fir_filter_sequencer.sv
// Directed bench for fir_filter_sequencer with a simple FIR stand-in that emits
// a programmable train of valid_out pulses after start rises.
module tb_fir_filter_sequencer;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0;
  logic             readback_req = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             busy, done, error;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;
  int lat = 5;
  int pulses = 8;
  int fir_t = 0;
  logic fir_on = 1'b0;
  logic start_q = 1'b0;
  int k_s;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, drain_cnt = 0, valid_cnt = 0;
  int wr_log[$];
  int rd_log[$];
  int in_log[$];
  int wb, ib, rb, db, vb, drb;

  fir_filter_sequencer_if #(.ADDR_W(ADDR_W)) filt();

  fir_filter_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DRAIN_TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .num_samples  (num_samples),
    .readback_req (readback_req),
    .filt         (filt),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  assign k_s = fir_on ? fir_t : 1;

  // FIR stand-in: from the rising edge of start, pulse valid_out for cycles lat..lat+pulses-1.
  always @(posedge clk) begin
    start_q <= filt.start;
    if (rst) begin
      fir_on         <= 1'b0;
      fir_t          <= 0;
      filt.valid_out <= 1'b0;
    end else if (fir_on || (filt.start && !start_q)) begin
      filt.valid_out <= (k_s >= lat) && (k_s < lat + pulses);
      fir_t          <= k_s + 1;
      fir_on         <= (k_s < lat + pulses);
    end else begin
      filt.valid_out <= 1'b0;
    end
  end

  // Observe the FIR-side bus mid-cycle and log addresses and events.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (filt.output_write_en) begin
      wr_log.push_back(int'(filt.output_address));
      last_wr_cyc <= cyc;
    end
    if (filt.output_read_en) rd_log.push_back(int'(filt.output_address));
    if (filt.input_read && filt.start) in_log.push_back(int'(filt.input_address));
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (filt.start && !filt.input_read) drain_cnt <= drain_cnt + 1;
    if (filt.valid_out === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int q[$], input int base, input int n);
    int bad = 0;
    check({tag, "_len"}, q.size() - base, n);
    for (int i = 0; i < n && base + i < q.size(); i++)
      if (q[base + i] != i) bad++;
    check({tag, "_seq_bad"}, bad, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_in_addr"}, filt.input_address, 0);
    check({tag, "_in_read"}, filt.input_read, 0);
    check({tag, "_start"}, filt.start, 0);
    check({tag, "_wr_en"}, filt.output_write_en, 0);
    check({tag, "_rd_en"}, filt.output_read_en, 0);
    check({tag, "_out_addr"}, filt.output_address, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  task automatic start_frame(input int n, input logic rb_req);
    @(posedge clk); #1;
    go           = 1'b1;
    num_samples  = n[CNT_W-1:0];
    readback_req = rb_req;
    @(posedge clk); #1;
    go           = 1'b0;
    readback_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Power-on reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 rst = 1'b0;

    // N=8, valid_out 5 cycles after start.
    lat = 5; pulses = 8;
    wb = wr_log.size(); ib = in_log.size(); db = done_cnt;
    start_frame(8, 1'b0);
    @(negedge clk);
    check("prime_in_read", filt.input_read, 1);
    check("prime_start", filt.start, 0);
    check("prime_in_addr", filt.input_address, 0);
    check("prime_busy", busy, 1);
    wait_done("n8", 100);
    check("n8_out_count", out_count, 8);
    check("n8_error", error, 0);
    idle_cycles(2);
    check("n8_busy_after", busy, 0);
    check("n8_done_cnt", done_cnt - db, 1);
    check("n8_done_latency", done_cyc - last_wr_cyc, 1);
    check_seq("n8_in", in_log, ib, 8);
    check_seq("n8_wr", wr_log, wb, 8);

    // Readback of the 8 captured samples.
    rb = rd_log.size(); db = done_cnt;
    @(posedge clk); #1 readback_req = 1'b1;
    @(posedge clk); #1 readback_req = 1'b0;
    @(negedge clk);
    check("rb_busy", busy, 1);
    wait_done("rb", 50);
    check("rb_out_count", out_count, 8);
    idle_cycles(2);
    check_seq("rb_rd", rd_log, rb, 8);
    check("rb_done_cnt", done_cnt - db, 1);

    // Reset in the middle of STREAM aborts without done.
    lat = 5; pulses = 8; db = done_cnt;
    start_frame(8, 1'b0);
    idle_cycles(3);
    check("mid_in_stream", filt.start, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("mid_rst");
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    idle_cycles(3);
    check_idle("post_rst");
    check("mid_rst_no_done", done_cnt - db, 0);

    // go and readback_req together: frame wins; N=4 with 6 valid_out pulses.
    lat = 1; pulses = 6;
    rb = rd_log.size(); wb = wr_log.size(); vb = valid_cnt;
    start_frame(4, 1'b1);
    @(negedge clk);
    check("go_wins_rd_en", filt.output_read_en, 0);
    check("go_wins_in_read", filt.input_read, 1);
    wait_done("sat", 50);
    check("sat_out_count", out_count, 4);
    idle_cycles(8);
    check("go_wins_no_readback", rd_log.size() - rb, 0);
    check("sat_valid_pulses", valid_cnt - vb, 6);
    check_seq("sat_wr", wr_log, wb, 4);

    // Drain timeout: only 2 of 4 outputs arrive.
    lat = 1; pulses = 2;
    wb = wr_log.size(); drb = drain_cnt;
    start_frame(4, 1'b0);
    wait_done("to", 200);
    check("to_error", error, 1);
    check("to_out_count", out_count, 2);
    idle_cycles(2);
    check("to_drain_cycles", drain_cnt - drb, 64);
    check("to_error_sticky", error, 1);
    check_seq("to_wr", wr_log, wb, 2);

    // Next accepted go clears error.
    lat = 1; pulses = 1;
    start_frame(1, 1'b0);
    @(negedge clk);
    check("clr_error", error, 0);
    wait_done("n1", 50);
    check("n1_out_count", out_count, 1);

    // Full-depth frame N=2048.
    lat = 3; pulses = 2048;
    wb = wr_log.size(); ib = in_log.size();
    start_frame(2048, 1'b0);
    wait_done("n2048", 2400);
    check("n2048_out_count", out_count, 2048);
    check("n2048_error", error, 0);
    idle_cycles(2);
    check_seq("n2048_in", in_log, ib, 2048);
    check_seq("n2048_wr", wr_log, wb, 2048);

    // N=0: immediate done, one busy cycle, no FIR activity.
    start_frame(0, 1'b0);
    @(negedge clk);
    check("n0_done", done, 1);
    check("n0_busy", busy, 1);
    check("n0_out_count", out_count, 0);
    check("n0_start", filt.start, 0);
    check("n0_in_read", filt.input_read, 0);
    check("n0_wr_en", filt.output_write_en, 0);
    check("n0_rd_en", filt.output_read_en, 0);
    @(negedge clk);
    check("n0_busy_after", busy, 0);
    check("n0_done_after", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
